// File: rtl/reset_seq_pkg.sv
// Shared types for the board reset sequencer: FSM states, reset-cause codes
// and a small elaboration-time helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  typedef logic [2:0] cause_t;

  localparam cause_t CAUSE_POR  = 3'd0;
  localparam cause_t CAUSE_LOCK = 3'd1;
  localparam cause_t CAUSE_BTN  = 3'd2;
  localparam cause_t CAUSE_SOFT = 3'd3;
  localparam cause_t CAUSE_WDT  = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_debouncer.sv
// Button conditioner: 2-FF synchroniser followed by a stable-count filter.
// o_level follows the synced input after DEBOUNCE_CYCLES stable cycles; o_rise pulses on its rising edge.
module reset_sequencer_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      if (r_sync != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync;
          r_rise  <= r_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: waits for PLL lock, then releases NUM_OUT resets in order.
// Optional watchdog trigger enabled by defining RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT         = 3,
  parameter int HOLD_CYCLES     = 32,
  parameter int STAGE_GAP       = 16,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int WDT_CYCLES      = 16777216
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               locked_i,
  input  logic               btn_i,
  input  logic               soft_reset_i,
  input  logic               wdt_kick_i,
  output logic [NUM_OUT-1:0] reset_o,
  output logic               done_o,
  output logic [2:0]         cause_o
);

  localparam int CW = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_OUT-1:0] r_reset, w_reset_nxt, w_reset_shift;
  logic               r_done, w_done_nxt;
  cause_t             r_cause, w_cause_nxt;
  logic               r_lock_meta, r_lock_sync;
  logic               w_btn_level, w_btn_rise;
  logic               w_wdt_expire;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= locked_i;
      r_lock_sync <= r_lock_meta;
    end
  end

  reset_sequencer_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .i_rst  (reset_i),
    .i_btn  (btn_i),
    .o_level(w_btn_level),
    .o_rise (w_btn_rise)
  );

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
  logic [WW-1:0] r_wdt_cnt;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_wdt_cnt <= '0;
    end else if ((w_state_nxt != RUN) || wdt_kick_i) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + 1'b1;
    end
  end

  assign w_wdt_expire = (r_state == RUN) && !wdt_kick_i && (r_wdt_cnt == WDT_LAST);
`else
  logic w_unused_kick;
  assign w_unused_kick = wdt_kick_i;
  assign w_wdt_expire  = 1'b0;
`endif

  // Outputs are released LSB first, so each release is a left shift of the mask.
  assign w_reset_shift = r_reset << 1;

  // NOTE: every next-state variable gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_reset_nxt = r_reset;
    w_done_nxt  = r_done;
    w_cause_nxt = r_cause;

    unique case (r_state)
      WAIT_LOCK: begin
        w_reset_nxt = '1;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        if (r_lock_sync) w_state_nxt = HOLD;
      end
      HOLD, RELEASE: begin
        if ((r_state == HOLD) && w_btn_level) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == ((r_state == HOLD) ? HOLD_LAST : GAP_LAST)) begin
          w_cnt_nxt   = '0;
          w_reset_nxt = w_reset_shift;
          if (w_reset_shift == '0) begin
            w_state_nxt = RUN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = RELEASE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        w_cnt_nxt = '0;
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase

    if (r_state != WAIT_LOCK) begin
      if (!r_lock_sync) begin
        w_state_nxt = WAIT_LOCK;
        w_cause_nxt = CAUSE_LOCK;
      end else if (w_btn_rise) begin
        w_state_nxt = HOLD;
        w_cause_nxt = CAUSE_BTN;
      end else if (soft_reset_i) begin
        w_state_nxt = HOLD;
        w_cause_nxt = CAUSE_SOFT;
      end else if (w_wdt_expire) begin
        w_state_nxt = HOLD;
        w_cause_nxt = CAUSE_WDT;
      end
      if (!r_lock_sync || w_btn_rise || soft_reset_i || w_wdt_expire) begin
        w_reset_nxt = '1;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
      r_reset <= '1;
      r_done  <= 1'b0;
      r_cause <= CAUSE_POR;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_reset <= w_reset_nxt;
      r_done  <= w_done_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  assign reset_o = r_reset;
  assign done_o  = r_done;
  assign cause_o = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: two instances (3 outputs, 1 output) checked through an expectation queue.
// Watchdog expectations follow RESET_SEQ_WATCHDOG_EN.
module tb_reset_sequencer;

  typedef struct packed {
    logic       sel_b;
    logic [2:0] rst;
    logic       done;
    logic [2:0] cause;
  } exp_t;

  logic clk;
  logic rst_a, locked_a, btn_a, soft_a, kick_a;
  logic rst_b, locked_b, btn_b, soft_b, kick_b;
  logic [2:0] reset_o_a;
  logic [0:0] reset_o_b;
  logic       done_a, done_b;
  logic [2:0] cause_a, cause_b;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  reset_sequencer #(
    .NUM_OUT(3), .HOLD_CYCLES(32), .STAGE_GAP(16), .DEBOUNCE_CYCLES(8), .WDT_CYCLES(100)
  ) dut_a (
    .clk(clk), .reset_i(rst_a), .locked_i(locked_a), .btn_i(btn_a),
    .soft_reset_i(soft_a), .wdt_kick_i(kick_a),
    .reset_o(reset_o_a), .done_o(done_a), .cause_o(cause_a)
  );

  reset_sequencer #(
    .NUM_OUT(1), .HOLD_CYCLES(4), .STAGE_GAP(16), .DEBOUNCE_CYCLES(8), .WDT_CYCLES(100000)
  ) dut_b (
    .clk(clk), .reset_i(rst_b), .locked_i(locked_b), .btn_i(btn_b),
    .soft_reset_i(soft_b), .wdt_kick_i(kick_b),
    .reset_o(reset_o_b), .done_o(done_b), .cause_o(cause_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic sel_b, input logic [2:0] r,
                          input logic d, input logic [2:0] c);
    exp_t e;
    e.sel_b = sel_b;
    e.rst   = r;
    e.done  = d;
    e.cause = c;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_next();
    exp_t  e;
    string tag;
    logic [6:0] obs;
    logic [6:0] want;
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs  = e.sel_b ? {2'b00, reset_o_b, done_b, cause_b} : {reset_o_a, done_a, cause_a};
    want = {e.rst, e.done, e.cause};
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed reset_o=%b done_o=%b cause_o=%0d, expected reset_o=%b done_o=%b cause_o=%0d",
             tag, obs[6:4], obs[3], obs[2:0], want[6:4], want[3], want[2:0]);
    end
  endtask

  task automatic step_a(input int n, input string tag, input logic [2:0] r, input logic d,
                        input logic [2:0] c);
    push_exp(tag, 1'b0, r, d, c);
    tick(n);
    check_next();
  endtask

  task automatic step_b(input int n, input string tag, input logic r, input logic d,
                        input logic [2:0] c);
    push_exp(tag, 1'b1, {2'b00, r}, d, c);
    tick(n);
    check_next();
  endtask

  // Full release sequence once the synced lock path starts seeing lock high on the next edge.
  task automatic seq_a(input logic [2:0] c);
    step_a(34, "hold_end", 3'b111, 1'b0, c);
    step_a(1,  "rel_bit0", 3'b110, 1'b0, c);
    step_a(15, "gap0_end", 3'b110, 1'b0, c);
    step_a(1,  "rel_bit1", 3'b100, 1'b0, c);
    step_a(15, "gap1_end", 3'b100, 1'b0, c);
    step_a(1,  "rel_bit2", 3'b000, 1'b1, c);
  endtask

  initial begin
    rst_a = 1'b1; locked_a = 1'b1; btn_a = 1'b0; soft_a = 1'b0; kick_a = 1'b0;
    rst_b = 1'b1; locked_b = 1'b1; btn_b = 1'b0; soft_b = 1'b0; kick_b = 1'b0;
    tick(2);
    push_exp("a_in_reset", 1'b0, 3'b111, 1'b0, 3'd0);
    check_next();
    push_exp("b_in_reset", 1'b1, 3'b001, 1'b0, 3'd0);
    check_next();

    // Single-output instance: release and done on the same edge.
    rst_b = 1'b0;
    step_b(6, "b_hold_end", 1'b1, 1'b0, 3'd0);
    step_b(1, "b_release",  1'b0, 1'b1, 3'd0);
    soft_b = 1'b1;
    step_b(1, "b_soft", 1'b1, 1'b0, 3'd3);
    soft_b = 1'b0;
    step_b(3, "b_soft_hold", 1'b1, 1'b0, 3'd3);
    step_b(1, "b_soft_rel",  1'b0, 1'b1, 3'd3);

    // Power-on sequence with lock already present.
    rst_a = 1'b0;
    seq_a(3'd0);

    // Lock loss in RUN, then relock.
    locked_a = 1'b0;
    step_a(2,  "lock_drop_sync", 3'b000, 1'b1, 3'd0);
    step_a(1,  "lock_lost",      3'b111, 1'b0, 3'd1);
    step_a(10, "wait_lock",      3'b111, 1'b0, 3'd1);
    locked_a = 1'b1;
    seq_a(3'd1);

    // Button bounce shorter than the debounce window.
    for (int i = 0; i < 3; i++) begin
      btn_a = 1'b1;
      tick(5);
      btn_a = 1'b0;
      tick(5);
    end
    step_a(10, "bounce_ignored", 3'b000, 1'b1, 3'd1);

    // 20-cycle press: HOLD for the whole press, release 32 cycles after debounced fall.
    btn_a = 1'b1;
    step_a(10, "press_pre",  3'b000, 1'b1, 3'd1);
    step_a(1,  "press_hold", 3'b111, 0,    3'd2);
    step_a(8,  "press_mid",  3'b111, 0,    3'd2);
    tick(1);
    btn_a = 1'b0;
    step_a(41, "btn_hold_end", 3'b111, 1'b0, 3'd2);
    step_a(1,  "btn_rel0",     3'b110, 1'b0, 3'd2);
    step_a(16, "btn_rel1",     3'b100, 1'b0, 3'd2);
    step_a(16, "btn_run",      3'b000, 1'b1, 3'd2);

    // Soft reset alone, then soft + lock loss together in RELEASE.
    soft_a = 1'b1;
    step_a(1, "soft", 3'b111, 1'b0, 3'd3);
    soft_a = 1'b0;
    step_a(31, "soft_hold", 3'b111, 1'b0, 3'd3);
    step_a(1,  "soft_rel0", 3'b110, 1'b0, 3'd3);
    locked_a = 1'b0;
    step_a(2, "pre_coincide", 3'b110, 1'b0, 3'd3);
    soft_a = 1'b1;
    step_a(1, "lock_beats_soft", 3'b111, 1'b0, 3'd1);
    soft_a = 1'b0;
    step_a(5, "coincide_wait", 3'b111, 1'b0, 3'd1);

    // Relock, then asynchronous reset in the middle of RELEASE.
    locked_a = 1'b1;
    step_a(35, "relock_rel0", 3'b110, 1'b0, 3'd1);
    step_a(5,  "mid_release", 3'b110, 1'b0, 3'd1);
    rst_a = 1'b1;
    push_exp("async_reset", 1'b0, 3'b111, 1'b0, 3'd0);
    #2;
    check_next();
    tick(3);
    rst_a = 1'b0;
    seq_a(3'd0);

    // Watchdog: kicks every 99 cycles, one kick on the terminal cycle, then silence.
    for (int i = 0; i < 3; i++) begin
      tick(98);
      kick_a = 1'b1;
      step_a(1, "kick_99", 3'b000, 1'b1, 3'd0);
      kick_a = 1'b0;
    end
    tick(99);
    kick_a = 1'b1;
    step_a(1, "kick_terminal", 3'b000, 1'b1, 3'd0);
    kick_a = 1'b0;
    step_a(99, "wdt_pre", 3'b000, 1'b1, 3'd0);
`ifdef RESET_SEQ_WATCHDOG_EN
    step_a(1,  "wdt_expire",    3'b111, 1'b0, 3'd4);
    step_a(31, "wdt_hold_end",  3'b111, 1'b0, 3'd4);
    step_a(1,  "wdt_rel0",      3'b110, 1'b0, 3'd4);
`else
    step_a(1,   "no_wdt_edge",  3'b000, 1'b1, 3'd0);
    step_a(200, "no_wdt_later", 3'b000, 1'b1, 3'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
